mult8_pp_sequencer: RTL



---
 rtl/mult8_pp_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult8_pp_sequencer.sv
// rtl/mult8_pp_sequencer.sv - time-multiplexed 2W x 2W multiplier built on one shared W x W sub-multiplier
module mult8_pp_sequencer #(
  parameter int SUB_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*SUB_W-1:0] a,
  input  logic [2*SUB_W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*SUB_W-1:0] p,
  output logic [SUB_W-1:0]   pp_a,
  output logic [SUB_W-1:0]   pp_b,
  input  logic [2*SUB_W-1:0] pp_p,
  output logic               busy
);

  localparam int OP_W = 2 * SUB_W;
  localparam int P_W  = 4 * SUB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic [1:0]      step;
  logic [OP_W-1:0] a_q;
  logic [OP_W-1:0] b_q;
  logic [P_W-1:0]  acc;
  logic [P_W-1:0]  p_q;
  logic [P_W-1:0]  pp_ext;
  logic [P_W-1:0]  pp_shifted;
  logic [P_W-1:0]  acc_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; DONE hands straight over to CALC when a
  // result is consumed in the same cycle as a new operand pair arrives
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (step == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Quadrant select for the shared sub-multiplier and weight of its product;
  // the cross terms (steps 1 and 2) share the same shift
  always_comb begin
    pp_a       = '0;
    pp_b       = '0;
    pp_ext     = {{(P_W-OP_W){1'b0}}, pp_p};
    pp_shifted = '0;
    if (state == CALC) begin
      case (step)
        2'd0: begin
          pp_a       = a_q[SUB_W-1:0];
          pp_b       = b_q[SUB_W-1:0];
          pp_shifted = pp_ext;
        end
        2'd1: begin
          pp_a       = a_q[SUB_W-1:0];
          pp_b       = b_q[OP_W-1:SUB_W];
          pp_shifted = pp_ext << SUB_W;
        end
        2'd2: begin
          pp_a       = a_q[OP_W-1:SUB_W];
          pp_b       = b_q[SUB_W-1:0];
          pp_shifted = pp_ext << SUB_W;
        end
        default: begin
          pp_a       = a_q[OP_W-1:SUB_W];
          pp_b       = b_q[OP_W-1:SUB_W];
          pp_shifted = pp_ext << (2 * SUB_W);
        end
      endcase
    end
  end

  assign acc_sum = acc + pp_shifted;

  // Operand latch, shift-accumulate and result register; p only moves on the
  // final step so it holds the previous result everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      step <= 2'd0;
      p_q  <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      step <= 2'd0;
    end else if (state == CALC) begin
      acc  <= acc_sum;
      step <= step + 2'd1;
      if (step == 2'd3) begin
        p_q <= acc_sum;
      end
    end
  end

  assign out_valid = (state == DONE);
  assign p         = p_q;

endmodule
